// File: rtl/load_store_unit_pkg.sv
// ----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the load/store unit: access-size encodings, FSM
// state encodings and a helper that turns a size code into a byte count.
// ----------------------------------------------------------------------------
package load_store_unit_pkg;

    // Access size as presented on the Size port (log2 of the byte count).
    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_REQ   = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Number of bytes touched by an access of the given size.
    function automatic int size_to_bytes(input size_e sz);
        return 1 << int'(sz);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// ----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational lane logic for the load/store unit (little-endian).
//   size_i        access size code
//   offset_i      byte offset of the access inside the memory word
//   unsigned_i    1 = zero-extend loads, 0 = sign-extend
//   store_data_i  right-justified store data
//   rdata_i       raw memory read word
//   byte_en_o     lane enables for the addressed bytes
//   wdata_o       store data replicated into every size-aligned slot
//   load_o        selected load lane, extended to DATA_W
// ----------------------------------------------------------------------------
module lsu_lane_align
    import load_store_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  size_e               size_i,
    input  logic [OFF_W-1:0]    offset_i,
    input  logic                unsigned_i,
    input  logic [DATA_W-1:0]   store_data_i,
    input  logic [DATA_W-1:0]   rdata_i,
    output logic [DATA_W/8-1:0] byte_en_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W-1:0]   load_o
);

    localparam int NB = DATA_W / 8;

    int                nb;
    int                off;
    logic [DATA_W-1:0] shifted;
    logic              sign;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the block leaves a value unassigned (no latch).
        byte_en_o = '0;
        wdata_o   = '0;
        load_o    = '0;

        // A dword code on a 32-bit bus is rejected upstream; clamping keeps
        // every index below in range regardless.
        nb      = (size_to_bytes(size_i) > NB) ? NB : size_to_bytes(size_i);
        off     = int'(offset_i);
        shifted = rdata_i >> (8 * off);
        sign    = !unsigned_i && shifted[nb*8-1];

        for (int k = 0; k < NB; k++) begin
            byte_en_o[k]     = (k >= off) && (k < off + nb);
            wdata_o[k*8 +: 8] = store_data_i[(k % nb)*8 +: 8];
            load_o[k*8 +: 8]  = (k < nb) ? shifted[k*8 +: 8] : {8{sign}};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Multi-cycle load/store engine between the datapath and a handshaked data
// memory. Sequence: IDLE -> CHECK -> REQ -> RESP -> IDLE.
//   Clk, Reset         clock, synchronous active-high reset
//   Start/IsStore/Size/Unsigned/Addr/StoreData   request (sampled in IDLE)
//   Busy               request in flight
//   Done               one-cycle completion pulse, with Misaligned / Error
//   LoadData           extended load result, held until the next load Done
//   MemReq/MemWe/MemAddr/MemByteEn/MemWData      memory request side
//   MemRData/MemAck    memory response side
// ----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic                IsStore,
    input  logic [1:0]          Size,
    input  logic                Unsigned,
    input  logic [ADDR_W-1:0]   Addr,
    input  logic [DATA_W-1:0]   StoreData,
    output logic                Busy,
    output logic                Done,
    output logic [DATA_W-1:0]   LoadData,
    output logic                Misaligned,
    output logic                Error,
    output logic                MemReq,
    output logic                MemWe,
    output logic [ADDR_W-1:0]   MemAddr,
    output logic [DATA_W/8-1:0] MemByteEn,
    output logic [DATA_W-1:0]   MemWData,
    input  logic [DATA_W-1:0]   MemRData,
    input  logic                MemAck
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e state_q, state_d;

    // Latched request
    logic              is_store_q;
    size_e             size_q;
    logic              unsigned_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] store_data_q;

    // Registered outputs
    logic              done_q, misaligned_q, error_q;
    logic [DATA_W-1:0] load_data_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [NB-1:0]     mem_be_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_we_q;
    logic [CNT_W-1:0]  cnt_q;

    // Events decoded by the next-state logic
    logic misalign_hit, ack_ok, timed_out;
    logic misalign_req;

    logic [NB-1:0]     align_be;
    logic [DATA_W-1:0] align_wdata, align_load;

    lsu_lane_align #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_align (
        .size_i       (size_q),
        .offset_i     (addr_q[OFF_W-1:0]),
        .unsigned_i   (unsigned_q),
        .store_data_i (store_data_q),
        .rdata_i      (MemRData),
        .byte_en_o    (align_be),
        .wdata_o      (align_wdata),
        .load_o       (align_load)
    );

    // Natural alignment: the offset must be a multiple of the access size,
    // and the access must fit the bus (rejects dword on a 32-bit bus).
    assign misalign_req = (size_to_bytes(size_q) > NB) ||
                          ((int'(addr_q[OFF_W-1:0]) % size_to_bytes(size_q)) != 0);

    // ---- state register ----
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // ---- next-state logic ----
    always_comb begin
        state_d      = state_q;
        misalign_hit = 1'b0;
        ack_ok       = 1'b0;
        timed_out    = 1'b0;
        case (state_q)
            ST_IDLE:  if (Start) state_d = ST_CHECK;
            ST_CHECK: begin
                if (misalign_req) begin
                    misalign_hit = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ:   state_d = ST_RESP;
            ST_RESP: begin
                // An acknowledge on the final allowed cycle beats the timeout.
                if (MemAck) begin
                    ack_ok  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timed_out = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---- output logic ----
    always_comb begin
        Busy       = (state_q != ST_IDLE);
        MemReq     = (state_q == ST_REQ) || (state_q == ST_RESP);
        MemWe      = MemReq && mem_we_q;
        Done       = done_q;
        Misaligned = misaligned_q;
        Error      = error_q;
        LoadData   = load_data_q;
        MemAddr    = mem_addr_q;
        MemByteEn  = mem_be_q;
        MemWData   = mem_wdata_q;
    end

    // ---- request latch, memory-side registers, result and timeout counter ----
    always_ff @(posedge Clk) begin
        // NOTE: the request latches are reset along with everything else so
        // the outputs derived from them come out of reset at a known zero.
        if (Reset) begin
            is_store_q   <= 1'b0;
            size_q       <= SZ_BYTE;
            unsigned_q   <= 1'b0;
            addr_q       <= '0;
            store_data_q <= '0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            error_q      <= 1'b0;
            load_data_q  <= '0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            error_q      <= 1'b0;

            if (state_q == ST_IDLE && Start) begin
                is_store_q   <= IsStore;
                size_q       <= size_e'(Size);
                unsigned_q   <= Unsigned;
                addr_q       <= Addr;
                store_data_q <= StoreData;
            end

            if (state_q == ST_CHECK) begin
                if (misalign_hit) begin
                    done_q       <= 1'b1;
                    misaligned_q <= 1'b1;
                end else begin
                    mem_addr_q  <= {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    mem_be_q    <= is_store_q ? align_be : {NB{1'b1}};
                    mem_wdata_q <= align_wdata;
                    mem_we_q    <= is_store_q;
                end
            end

            if (state_q == ST_REQ) cnt_q <= '0;

            if (state_q == ST_RESP) begin
                if (ack_ok) begin
                    done_q <= 1'b1;
                    if (!is_store_q) load_data_q <= align_load;
                end else if (timed_out) begin
                    done_q  <= 1'b1;
                    error_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
// Table of single-transaction vectors with a scoreboard queue (expected result
// pushed at Start, popped at Done), followed by hand-written sequences for
// reset mid-transaction, Start while busy and Start coinciding with Done.
// Latency is counted in rising edges after the edge that accepts Start.
// ----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, is_store, uns;
    logic [1:0]  size;
    logic [31:0] addr, sdata;
    logic        busy, done, mis, err;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ack;

    load_store_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .Clk        (clk),
        .Reset      (reset),
        .Start      (start),
        .IsStore    (is_store),
        .Size       (size),
        .Unsigned   (uns),
        .Addr       (addr),
        .StoreData  (sdata),
        .Busy       (busy),
        .Done       (done),
        .LoadData   (load_data),
        .Misaligned (mis),
        .Error      (err),
        .MemReq     (mem_req),
        .MemWe      (mem_we),
        .MemAddr    (mem_addr),
        .MemByteEn  (mem_be),
        .MemWData   (mem_wdata),
        .MemRData   (mem_rdata),
        .MemAck     (mem_ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rd;
        int          ack_at;   // negedge index at which MemAck is driven (0 = never)
        logic [31:0] e_load;
        logic        e_mis;
        logic        e_err;
        int          e_lat;
        logic [31:0] e_maddr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
    } vec_t;

    typedef struct {
        logic [31:0] load;
        logic        mis;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[15];

    task automatic run_vec(input vec_t v, input string tag);
        int   done_n;
        int   req_seen;
        bit   req_checked;
        exp_t e;
        @(negedge clk);
        start = 1'b1; is_store = v.st; size = v.sz; uns = v.un;
        addr = v.a; sdata = v.sd; mem_rdata = v.rd; mem_ack = 1'b0;
        sb_q.push_back('{load: v.e_load, mis: v.e_mis, err: v.e_err, lat: v.e_lat});
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy"}, 64'(busy), 64'(1));
        done_n = -1; req_seen = 0; req_checked = 0;
        for (int n = 1; n <= 40 && done_n < 0; n++) begin
            @(negedge clk);
            if (mem_req) begin
                req_seen++;
                if (!req_checked) begin
                    req_checked = 1;
                    check({tag, " MemAddr"}, 64'(mem_addr), 64'(v.e_maddr));
                    check({tag, " MemByteEn"}, 64'(mem_be), 64'(v.e_be));
                    check({tag, " MemWe"}, 64'(mem_we), 64'(v.st));
                    if (v.st) check({tag, " MemWData"}, 64'(mem_wdata), 64'(v.e_wdata));
                end
            end
            if (done) begin
                done_n = n;
                if (sb_q.size() == 0) begin
                    check({tag, " done with empty scoreboard"}, 64'(0), 64'(1));
                end else begin
                    e = sb_q.pop_front();
                    check({tag, " latency"}, 64'(done_n), 64'(e.lat));
                    check({tag, " LoadData"}, 64'(load_data), 64'(e.load));
                    check({tag, " Misaligned"}, 64'(mis), 64'(e.mis));
                    check({tag, " Error"}, 64'(err), 64'(e.err));
                    check({tag, " MemReq after done"}, 64'(mem_req), 64'(0));
                end
            end
            mem_ack = (done_n < 0) && (n == v.ack_at);
        end
        mem_ack = 1'b0;
        if (done_n < 0) begin
            check({tag, " Done within bound"}, 64'(0), 64'(1));
            sb_q.delete();
        end
        check({tag, " MemReq issued"}, 64'(req_seen != 0), 64'(!v.e_mis));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dones;
        int mis_seen;

        //          st  sz  un  addr   sdata         rdata         ack  e_load        mis err lat       maddr  be     wdata
        vecs[0]  = '{0, 2, 0, 32'h100, 32'h0,        32'h8899AABB, 2,  32'h8899AABB, 0, 0, 3,      32'h100, 4'hF, 32'h0};
        vecs[1]  = '{0, 0, 0, 32'h103, 32'h0,        32'h80112233, 2,  32'hFFFFFF80, 0, 0, 3,      32'h100, 4'hF, 32'h0};
        vecs[2]  = '{0, 0, 1, 32'h103, 32'h0,        32'h80112233, 2,  32'h00000080, 0, 0, 3,      32'h100, 4'hF, 32'h0};
        vecs[3]  = '{0, 1, 0, 32'h102, 32'h0,        32'h80112233, 2,  32'hFFFF8011, 0, 0, 3,      32'h100, 4'hF, 32'h0};
        vecs[4]  = '{0, 1, 1, 32'h102, 32'h0,        32'h80112233, 2,  32'h00008011, 0, 0, 3,      32'h100, 4'hF, 32'h0};
        vecs[5]  = '{1, 1, 0, 32'h202, 32'h0000BEEF, 32'h0,        2,  32'h00008011, 0, 0, 3,      32'h200, 4'hC, 32'hBEEFBEEF};
        vecs[6]  = '{1, 0, 0, 32'h301, 32'h123456A5, 32'h0,        2,  32'h00008011, 0, 0, 3,      32'h300, 4'h2, 32'hA5A5A5A5};
        vecs[7]  = '{1, 2, 0, 32'h304, 32'hDEADBEEF, 32'h0,        4,  32'h00008011, 0, 0, 5,      32'h304, 4'hF, 32'hDEADBEEF};
        vecs[8]  = '{0, 2, 0, 32'h101, 32'h0,        32'h12345678, 2,  32'h00008011, 1, 0, 1,      32'h0,   4'h0, 32'h0};
        vecs[9]  = '{0, 3, 0, 32'h108, 32'h0,        32'h12345678, 2,  32'h00008011, 1, 0, 1,      32'h0,   4'h0, 32'h0};
        vecs[10] = '{0, 1, 0, 32'h103, 32'h0,        32'h12345678, 2,  32'h00008011, 1, 0, 1,      32'h0,   4'h0, 32'h0};
        vecs[11] = '{0, 2, 0, 32'h110, 32'h0,        32'hCAFEF00D, 0,  32'h00008011, 0, 1, 2 + TO, 32'h110, 4'hF, 32'h0};
        vecs[12] = '{0, 2, 0, 32'h110, 32'h0,        32'hCAFEF00D, 1 + TO, 32'hCAFEF00D, 0, 0, 2 + TO, 32'h110, 4'hF, 32'h0};
        vecs[13] = '{0, 2, 0, 32'h114, 32'h0,        32'h11111111, 1,  32'hCAFEF00D, 0, 1, 2 + TO, 32'h114, 4'hF, 32'h0};
        vecs[14] = '{0, 0, 0, 32'h102, 32'h0,        32'h007F0000, 2,  32'h0000007F, 0, 0, 3,      32'h100, 4'hF, 32'h0};

        reset = 1'b1; start = 1'b0; is_store = 1'b0; size = 2'd0; uns = 1'b0;
        addr = '0; sdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("reset Busy", 64'(busy), 64'(0));
        check("reset Done", 64'(done), 64'(0));
        check("reset MemReq", 64'(mem_req), 64'(0));
        check("reset MemWe", 64'(mem_we), 64'(0));
        check("reset LoadData", 64'(load_data), 64'(0));
        check("reset MemAddr", 64'(mem_addr), 64'(0));
        check("reset MemByteEn", 64'(mem_be), 64'(0));
        check("reset MemWData", 64'(mem_wdata), 64'(0));
        check("reset Misaligned/Error", 64'({mis, err}), 64'(0));
        reset = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while waiting in RESP: everything back to reset values, no Done.
        @(negedge clk);
        start = 1'b1; is_store = 1'b1; size = 2'd2; addr = 32'h400; sdata = 32'h01020304;
        @(negedge clk); start = 1'b0;      // CHECK
        @(negedge clk);                    // REQ
        @(negedge clk);                    // RESP
        check("rst-mid MemReq before", 64'(mem_req), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst-mid MemReq", 64'(mem_req), 64'(0));
        check("rst-mid MemWe", 64'(mem_we), 64'(0));
        check("rst-mid Busy", 64'(busy), 64'(0));
        check("rst-mid Done", 64'(done), 64'(0));
        check("rst-mid LoadData", 64'(load_data), 64'(0));
        check("rst-mid MemAddr/ByteEn", 64'({mem_addr, mem_be}), 64'(0));
        check("rst-mid MemWData", 64'(mem_wdata), 64'(0));
        // A stray MemAck while idle must not produce a Done.
        mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("rst-mid no Done", 64'(dones), 64'(0));

        // Start while busy is ignored: one Done, for the first request only.
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h120;
        mem_rdata = 32'h5A5A0001;
        @(negedge clk); start = 1'b0;      // CHECK
        @(negedge clk);                    // REQ
        start = 1'b1; addr = 32'h121;      // misaligned second request while busy
        @(negedge clk);                    // RESP
        start = 1'b0; mem_ack = 1'b1;
        dones = 0; mis_seen = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (done) begin
                dones++;
                if (mis) mis_seen++;
                if (dones == 1) check("busy-start LoadData", 64'(load_data), 64'(32'h5A5A0001));
            end
        end
        check("busy-start single Done", 64'(dones), 64'(1));
        check("busy-start no Misaligned", 64'(mis_seen), 64'(0));

        // Start in the same cycle as Done is accepted.
        @(negedge clk);
        start = 1'b1; size = 2'd2; addr = 32'h101;
        @(negedge clk); start = 1'b0;      // CHECK
        @(negedge clk);                    // Done (misaligned), IDLE
        check("done-start Done", 64'({done, mis}), 64'(2'b11));
        start = 1'b1; size = 2'd2; addr = 32'h124; mem_rdata = 32'h600D600D;
        @(negedge clk); start = 1'b0;      // CHECK
        check("done-start Busy", 64'(busy), 64'(1));
        @(negedge clk);                    // REQ
        @(negedge clk);                    // RESP
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("done-start second Done", 64'({done, err}), 64'(2'b10));
        check("done-start LoadData", 64'(load_data), 64'(32'h600D600D));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
